apb_script_master: RTL and testbench

- Parametrised APB master that replays a programmable script of APB transactions into a downstream APB slave, such as apb_i2c_bridge.
- Replaces fixed ROM-plus-selector stimulus with:
  - a writable script RAM;
  - a synchronised start strobe;
  - full SETUP/ACCESS sequencing with PREADY wait states, PSLVERR abort and a watchdog timeout.
- Sits between board-level controls or a host and the bridge; captures read data per transaction.

---
 rtl/apb_script_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_apb_script_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_script_master.sv
// apb_script_master: replays a writable RAM script of APB transfers into a
// slave, with synchronised start, wait states, slave-error abort and watchdog.
module apb_script_master #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 4,
   parameter int IDX_W      = $clog2(DEPTH),
   parameter int TIMEOUT    = 255,
   parameter int SYNC_START = 1
) (
   input  logic                     PCLK,
   input  logic                     PRESETn,
   input  logic                     prog_we,
   input  logic [IDX_W-1:0]         prog_idx,
   input  logic [ADDR_W+DATA_W+1:0] prog_entry,
   input  logic                     start,
   input  logic [IDX_W-1:0]         start_idx,
   input  logic                     step_mode,
   input  logic                     abort,
   output logic                     PSELx,
   output logic                     PENABLE,
   output logic                     PWRITE,
   output logic [ADDR_W-1:0]        PADDR,
   output logic [DATA_W-1:0]        PWDATA,
   input  logic [DATA_W-1:0]        PRDATA,
   input  logic                     PREADY,
   input  logic                     PSLVERR,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [1:0]               err_code,
   output logic [IDX_W-1:0]         cur_idx,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid
);

   localparam int EW   = ADDR_W + DATA_W + 2;
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      NEXT
   } state_t;

   state_t state_q, state_d;

   logic [EW-1:0]     mem_q [DEPTH];
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              last_q, last_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;
   logic [DATA_W-1:0] rdat_q, rdat_d;
   logic              rvld_q, rvld_d;
   logic              done_q, done_d;
   logic              resume_q, resume_d;
   logic              apend_q, apend_d;
   logic              prev_q;

   logic              start_s;
   logic              start_edge;
   logic              load;
   logic [IDX_W-1:0]  inc_idx;
   logic [IDX_W-1:0]  load_idx;
   logic [EW-1:0]     ent;

   generate
      if (SYNC_START != 0) begin : g_sync
         logic s1_q;
         logic s2_q;
         always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
               s1_q <= 1'b0;
               s2_q <= 1'b0;
            end else begin
               s1_q <= start;
               s2_q <= s1_q;
            end
         end
         assign start_s = s2_q;
      end else begin : g_direct
         assign start_s = start;
      end
   endgenerate

   assign start_edge = start_s & ~prev_q;

   // Script RAM is frozen while a run is active so the bus fields never tear.
   always_ff @(posedge PCLK) begin
      if (prog_we && (state_q == IDLE)) begin
         mem_q[prog_idx] <= prog_entry;
      end
   end

   assign inc_idx  = idx_q + IDX_W'(1);
   assign load_idx = ((state_q == IDLE) && !resume_q) ? start_idx : inc_idx;
   assign ent      = mem_q[load_idx];

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wd_d     = wd_q;
      err_d    = err_q;
      code_d   = code_q;
      rdat_d   = rdat_q;
      rvld_d   = 1'b0;
      done_d   = 1'b0;
      resume_d = resume_q;
      apend_d  = apend_q;
      load     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d  = SETUP;
               load     = 1'b1;
               err_d    = 1'b0;
               code_d   = 2'b00;
               resume_d = 1'b0;
               apend_d  = 1'b0;
            end
         end
         SETUP: begin
            if (abort) begin
               state_d  = IDLE;
               code_d   = 2'b11;
               resume_d = 1'b0;
            end else begin
               state_d = ACCESS;
               wd_d    = '0;
            end
         end
         ACCESS: begin
            // Abort cannot cut a live transfer; remember it for NEXT.
            if (abort) begin
               apend_d = 1'b1;
            end
            if (PREADY && PSLVERR) begin
               state_d  = IDLE;
               err_d    = 1'b1;
               code_d   = 2'b01;
               resume_d = 1'b0;
            end else if (PREADY) begin
               state_d = NEXT;
               if (!wr_q) begin
                  rdat_d = PRDATA;
                  rvld_d = 1'b1;
               end
            end else if (wd_q == WD_MAX) begin
               state_d  = IDLE;
               err_d    = 1'b1;
               code_d   = 2'b10;
               resume_d = 1'b0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         NEXT: begin
            if (abort || apend_q) begin
               state_d  = IDLE;
               code_d   = 2'b11;
               resume_d = 1'b0;
               apend_d  = 1'b0;
            end else if (last_q || (idx_q == LAST_IDX)) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               resume_d = 1'b0;
            end else if (step_mode) begin
               state_d  = IDLE;
               resume_d = 1'b1;
            end else begin
               state_d = SETUP;
               load    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         idx_d = load_idx;
         {last_d, wr_d, addr_d, wdata_d} = ent;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         last_q   <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
         code_q   <= 2'b00;
         rdat_q   <= '0;
         rvld_q   <= 1'b0;
         done_q   <= 1'b0;
         resume_q <= 1'b0;
         apend_q  <= 1'b0;
         prev_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
         code_q   <= code_d;
         rdat_q   <= rdat_d;
         rvld_q   <= rvld_d;
         done_q   <= done_d;
         resume_q <= resume_d;
         apend_q  <= apend_d;
         prev_q   <= start_s;
      end
   end

   assign PSELx    = (state_q == SETUP) || (state_q == ACCESS);
   assign PENABLE  = (state_q == ACCESS);
   assign PWRITE   = wr_q;
   assign PADDR    = addr_q;
   assign PWDATA   = wdata_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = code_q;
   assign cur_idx  = idx_q;
   assign rd_data  = rdat_q;
   assign rd_valid = rvld_q;

endmodule

// File: tb/tb_apb_script_master.sv
// tb_apb_script_master: table vectors, hand-written corner sequences and
// randomized scripts checked against a transfer-level model.
module tb_apb_script_master;

   localparam int AW  = 7;
   localparam int DW  = 8;
   localparam int DEP = 4;
   localparam int IW  = 2;
   localparam int TO  = 8;

   logic              PCLK = 1'b0;
   logic              PRESETn = 1'b0;
   logic              prog_we = 1'b0;
   logic [IW-1:0]     prog_idx = '0;
   logic [AW+DW+1:0]  prog_entry = '0;
   logic              start = 1'b0;
   logic [IW-1:0]     start_idx = '0;
   logic              step_mode = 1'b0;
   logic              abort = 1'b0;
   logic              PSELx, PENABLE, PWRITE;
   logic [AW-1:0]     PADDR;
   logic [DW-1:0]     PWDATA, PRDATA, rd_data;
   logic              PREADY, PSLVERR;
   logic              busy, done, err, rd_valid;
   logic [1:0]        err_code;
   logic [IW-1:0]     cur_idx;

   apb_script_master #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .IDX_W(IW),
      .TIMEOUT(TO), .SYNC_START(1)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .prog_we(prog_we), .prog_idx(prog_idx), .prog_entry(prog_entry),
      .start(start), .start_idx(start_idx), .step_mode(step_mode),
      .abort(abort),
      .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .cur_idx(cur_idx), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   always #5 PCLK = ~PCLK;

   // slave model: per-transfer wait count, error on one transfer ordinal
   int        sl_wait [8];
   int        err_at = 99;
   logic      stuck = 1'b0;
   logic [7:0] rd_base = 8'h5A;
   logic      rd_mix = 1'b0;
   int        acc_cnt, xfer_no;

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         acc_cnt <= 0;
         xfer_no <= 0;
      end else begin
         acc_cnt <= (PSELx && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
         if (!busy) xfer_no <= 0;
         else if (PSELx && PENABLE && PREADY) xfer_no <= xfer_no + 1;
      end
   end

   assign PREADY  = PSELx && PENABLE && !stuck &&
                    (acc_cnt >= sl_wait[xfer_no & 7]);
   assign PSLVERR = PREADY && (xfer_no == err_at);
   assign PRDATA  = rd_base ^ (rd_mix ? {1'b0, PADDR} : 8'h00);

   logic       sc_last [DEP];
   logic       sc_w    [DEP];
   logic [6:0] sc_addr [DEP];
   logic [7:0] sc_wd   [DEP];

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [15:0] obs_q [$];
   logic [7:0]  rd_q [$];
   int          setup_cyc [$];
   int          done_n, max_acc, acc_len, unstable;
   logic [15:0] su_v;
   logic [15:0] exp_x [$];
   logic [7:0]  exp_r [$];
   int          exp_done;
   logic        exp_err;
   logic [1:0]  exp_code;
   int          t0;

   typedef struct {
      int         sidx;
      int         wait_ord;
      int         wait_n;
      int         err_at;
      logic       stuck;
      int         n_x;
      int         n_rd;
      int         n_done;
      logic       e;
      logic [1:0] code;
      int         max_acc;
   } vec_t;

   vec_t vt [6];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge PCLK);
      cyc++;
      if (PRESETn) begin
         if (PSELx && !PENABLE) begin
            setup_cyc.push_back(cyc);
            su_v = {PWRITE, PADDR, PWDATA};
            acc_len = 0;
         end
         if (PSELx && PENABLE) begin
            acc_len++;
            if (acc_len > max_acc) max_acc = acc_len;
            if ({PWRITE, PADDR, PWDATA} !== su_v) unstable++;
            if (PREADY) obs_q.push_back({PWRITE, PADDR, PWDATA});
         end
         if (rd_valid) rd_q.push_back(rd_data);
         if (done) done_n++;
      end
   endtask

   task automatic clear_obs();
      obs_q.delete();
      rd_q.delete();
      setup_cyc.delete();
      done_n = 0;
      max_acc = 0;
      acc_len = 0;
      unstable = 0;
   endtask

   task automatic wait_busy(input logic lvl, input int lim, input string nm);
      int n;
      n = 0;
      while (busy !== lvl && n < lim) begin
         tick();
         n++;
      end
      if (busy !== lvl) begin
         total++;
         bad++;
         $display("FAIL %s: busy wait expired got %0b want %0b", nm, busy, lvl);
      end
   endtask

   task automatic do_run(input int sidx, input logic stp, input string nm);
      clear_obs();
      start_idx = IW'(sidx);
      step_mode = stp;
      t0 = cyc;
      start = 1'b1;
      wait_busy(1'b1, 10, nm);
      wait_busy(1'b0, 300, nm);
      repeat (3) tick();
      start = 1'b0;
      repeat (3) tick();
   endtask

   task automatic prog_all();
      for (int i = 0; i < DEP; i++) begin
         prog_we = 1'b1;
         prog_idx = IW'(i);
         prog_entry = {sc_last[i], sc_w[i], sc_addr[i], sc_wd[i]};
         tick();
      end
      prog_we = 1'b0;
   endtask

   // Transfer-level model: walk the script, applying the slave's behaviour.
   task automatic model(input int sidx);
      int i;
      int k;
      i = sidx;
      k = 0;
      exp_x.delete();
      exp_r.delete();
      exp_done = 0;
      exp_err = 1'b0;
      exp_code = 2'b00;
      while (1) begin
         if (stuck) begin
            exp_err = 1'b1;
            exp_code = 2'b10;
            break;
         end
         exp_x.push_back({sc_w[i], sc_addr[i], sc_wd[i]});
         if (k == err_at) begin
            exp_err = 1'b1;
            exp_code = 2'b01;
            break;
         end
         if (!sc_w[i]) exp_r.push_back(rd_base ^ (rd_mix ? {1'b0, sc_addr[i]} : 8'h00));
         if (sc_last[i] || i == DEP - 1) begin
            exp_done = 1;
            break;
         end
         i++;
         k++;
      end
   endtask

   task automatic cmp_run(input string nm);
      chk({nm, ".nx"}, 64'(obs_q.size()), 64'(exp_x.size()));
      for (int k = 0; k < exp_x.size() && k < obs_q.size(); k++)
         chk({nm, ".xfer"}, 64'(obs_q[k]), 64'(exp_x[k]));
      chk({nm, ".nrd"}, 64'(rd_q.size()), 64'(exp_r.size()));
      for (int k = 0; k < exp_r.size() && k < rd_q.size(); k++)
         chk({nm, ".rd"}, 64'(rd_q[k]), 64'(exp_r[k]));
      chk({nm, ".done"}, 64'(done_n), 64'(exp_done));
      chk({nm, ".err"}, 64'(err), 64'(exp_err));
      chk({nm, ".code"}, 64'(err_code), 64'(exp_code));
      chk({nm, ".busy"}, 64'(busy), 64'd0);
      chk({nm, ".stable"}, 64'(unstable), 64'd0);
   endtask

   initial begin
      int sidx;
      for (int j = 0; j < 8; j++) sl_wait[j] = 0;
      sc_w[0] = 1'b1; sc_addr[0] = 7'h10; sc_wd[0] = 8'hA5; sc_last[0] = 1'b0;
      sc_w[1] = 1'b1; sc_addr[1] = 7'h11; sc_wd[1] = 8'h3C; sc_last[1] = 1'b0;
      sc_w[2] = 1'b0; sc_addr[2] = 7'h12; sc_wd[2] = 8'h00; sc_last[2] = 1'b0;
      sc_w[3] = 1'b0; sc_addr[3] = 7'h13; sc_wd[3] = 8'h00; sc_last[3] = 1'b1;

      // sidx wait_ord wait_n err_at stuck | n_x n_rd done err code max_acc
      vt[0] = '{0, 0, 0, 99, 1'b0, 4, 2, 1, 1'b0, 2'd0, 1};
      vt[1] = '{0, 1, 5, 99, 1'b0, 4, 2, 1, 1'b0, 2'd0, 6};
      vt[2] = '{0, 0, 0, 99, 1'b1, 0, 0, 0, 1'b1, 2'd2, 8};
      vt[3] = '{0, 0, 0, 2,  1'b0, 3, 0, 0, 1'b1, 2'd1, 1};
      vt[4] = '{2, 0, 0, 99, 1'b0, 2, 2, 1, 1'b0, 2'd0, 1};
      vt[5] = '{3, 0, 0, 0,  1'b0, 1, 0, 0, 1'b1, 2'd1, 1};

      repeat (2) tick();
      chk("reset.bus", 64'({PSELx, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
      chk("reset.status", 64'({busy, done, err, err_code, cur_idx, rd_data, rd_valid}), 64'd0);
      PRESETn = 1'b1;
      tick();
      prog_all();

      for (int v = 0; v < 6; v++) begin
         vec_t t;
         t = vt[v];
         for (int j = 0; j < 8; j++) sl_wait[j] = 0;
         sl_wait[t.wait_ord] = t.wait_n;
         err_at = t.err_at;
         stuck = t.stuck;
         do_run(t.sidx, 1'b0, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d.nx", v), 64'(obs_q.size()), 64'(t.n_x));
         chk($sformatf("vec%0d.nrd", v), 64'(rd_q.size()), 64'(t.n_rd));
         chk($sformatf("vec%0d.done", v), 64'(done_n), 64'(t.n_done));
         chk($sformatf("vec%0d.err", v), 64'(err), 64'(t.e));
         chk($sformatf("vec%0d.code", v), 64'(err_code), 64'(t.code));
         chk($sformatf("vec%0d.penable", v), 64'(max_acc), 64'(t.max_acc));
         chk($sformatf("vec%0d.stable", v), 64'(unstable), 64'd0);
         chk($sformatf("vec%0d.busy", v), 64'(busy), 64'd0);
         for (int k = 0; k < obs_q.size(); k++)
            chk($sformatf("vec%0d.addr%0d", v, k), 64'(obs_q[k][14:8]),
                64'(7'h10 + 7'(t.sidx + k)));
         for (int k = 0; k < rd_q.size(); k++)
            chk($sformatf("vec%0d.rd%0d", v, k), 64'(rd_q[k]), 64'h5A);
      end
      stuck = 1'b0;
      err_at = 99;
      for (int j = 0; j < 8; j++) sl_wait[j] = 0;

      do_run(0, 1'b0, "lat");
      chk("lat.n", 64'(setup_cyc.size()), 64'd4);
      chk("lat.first", 64'(setup_cyc[0] - t0), 64'd3);
      chk("lat.gap01", 64'(setup_cyc[1] - setup_cyc[0]), 64'd3);
      chk("lat.gap23", 64'(setup_cyc[3] - setup_cyc[2]), 64'd3);

      // step mode: entry 3 not marked last; RAM end must still finish
      sc_last[3] = 1'b0;
      prog_all();
      for (int j = 0; j < 8; j++) sl_wait[j] = 6;
      clear_obs();
      start_idx = 2'd1;
      step_mode = 1'b1;
      start = 1'b1;
      wait_busy(1'b1, 10, "step1");
      start = 1'b0;
      prog_we = 1'b1;
      prog_idx = 2'd2;
      prog_entry = '1;
      tick();
      prog_we = 1'b0;
      repeat (2) tick();
      start = 1'b1;
      repeat (3) tick();
      wait_busy(1'b0, 100, "step1");
      repeat (3) tick();
      start = 1'b0;
      repeat (3) tick();
      chk("step1.nx", 64'(obs_q.size()), 64'd1);
      chk("step1.addr", 64'(obs_q.size() > 0 ? obs_q[0][14:8] : 7'h7F), 64'h11);
      chk("step1.done", 64'(done_n), 64'd0);
      chk("step1.idx", 64'(cur_idx), 64'd1);

      do_run(0, 1'b1, "step2");
      chk("step2.nx", 64'(obs_q.size()), 64'd1);
      chk("step2.xfer", 64'(obs_q.size() > 0 ? obs_q[0] : 16'hFFFF),
          64'({sc_w[2], sc_addr[2], sc_wd[2]}));
      chk("step2.done", 64'(done_n), 64'd0);
      chk("step2.rd", 64'(rd_q.size()), 64'd1);

      do_run(0, 1'b1, "step3");
      chk("step3.nx", 64'(obs_q.size()), 64'd1);
      chk("step3.addr", 64'(obs_q.size() > 0 ? obs_q[0][14:8] : 7'h7F), 64'h13);
      chk("step3.done", 64'(done_n), 64'd1);

      do_run(1, 1'b1, "step4");
      chk("step4.nx", 64'(obs_q.size()), 64'd1);
      chk("step4.addr", 64'(obs_q.size() > 0 ? obs_q[0][14:8] : 7'h7F), 64'h11);
      chk("step4.done", 64'(done_n), 64'd0);

      sc_last[3] = 1'b1;
      prog_all();
      for (int j = 0; j < 8; j++) sl_wait[j] = 0;

      abort = 1'b1;
      do_run(0, 1'b0, "abort");
      abort = 1'b0;
      chk("abort.nx", 64'(obs_q.size()), 64'd0);
      chk("abort.code", 64'(err_code), 64'd3);
      chk("abort.err", 64'(err), 64'd0);
      chk("abort.done", 64'(done_n), 64'd0);

      // reset in the middle of a stalled ACCESS
      stuck = 1'b1;
      clear_obs();
      start_idx = 2'd0;
      step_mode = 1'b0;
      start = 1'b1;
      for (int n = 0; n < 20 && !PENABLE; n++) tick();
      repeat (2) tick();
      chk("rst.pre_pen", 64'(PENABLE), 64'd1);
      #2 PRESETn = 1'b0;
      #1;
      chk("rst.psel", 64'(PSELx), 64'd0);
      chk("rst.pen", 64'(PENABLE), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      start = 1'b0;
      stuck = 1'b0;
      repeat (2) tick();
      PRESETn = 1'b1;
      repeat (2) tick();
      do_run(0, 1'b0, "rst_run");
      model(0);
      cmp_run("rst_run");

      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < DEP; i++) begin
            sc_w[i] = 1'($urandom_range(0, 1));
            sc_addr[i] = 7'($urandom);
            sc_wd[i] = 8'($urandom);
            sc_last[i] = ($urandom_range(0, 3) == 0);
         end
         prog_all();
         for (int j = 0; j < 8; j++) sl_wait[j] = $urandom_range(0, 3);
         err_at = $urandom_range(0, 9);
         rd_base = 8'($urandom);
         rd_mix = 1'b1;
         sidx = $urandom_range(0, DEP - 1);
         do_run(sidx, 1'b0, $sformatf("rnd%0d", r));
         model(sidx);
         cmp_run($sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
